// File: rtl/sdram_boot_arbiter_pkg.sv
// Shared types and defaults for the SDRAM boot arbiter.
// State encoding is fixed so it matches the legacy localparam values.
package sdram_boot_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 22;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Round-robin pick among eligible masters; last_gnt = 1 means M0 wins a tie.
  function automatic arb_state_t rr_pick(input logic req0, input logic req1,
                                         input logic last_gnt);
    arb_state_t nxt;
    nxt = IDLE;
    if (req0 && (!req1 || last_gnt)) nxt = GNT0;
    else if (req1)                   nxt = GNT1;
    return nxt;
  endfunction

endpackage

// File: rtl/sdram_boot_arbiter_boot_reset_hold.sv
// Boot-done capture and CPU reset stretch: o_CPU_Reset drops
// BOOT_HOLD_CYCLES+1 edges after i_Boot_Done is first sampled high.
module boot_reset_hold #(
  parameter int unsigned BOOT_HOLD_CYCLES = 16
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Boot_Done,
  output logic o_Boot_Done_Seen,
  output logic o_CPU_Reset
);

  logic [7:0] hold_cnt;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Boot_Done_Seen <= 1'b0;
      hold_cnt         <= 8'(BOOT_HOLD_CYCLES);
      o_CPU_Reset      <= 1'b1;
    end else begin
      if (i_Boot_Done) o_Boot_Done_Seen <= 1'b1;
      if (o_Boot_Done_Seen && (hold_cnt != '0)) hold_cnt <= hold_cnt - 8'd1;
      // Registered compare adds the extra edge after the count hits zero.
      o_CPU_Reset <= (hold_cnt != '0);
    end
  end

endmodule

// File: rtl/sdram_boot_arbiter.sv
// Two-master burst arbiter in front of the SDRAM controller; the CPU
// port (M1) is masked until the boot loader reports done.
module sdram_boot_arbiter
  import sdram_boot_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned BOOT_HOLD_CYCLES = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Boot_Done,
  output logic                  o_CPU_Reset,

  input  logic [ADDR_WIDTH-1:0] i_M0_Addr,
  input  logic                  i_M0_Req_Valid,
  input  logic                  i_M0_Read_Write_n,
  input  logic [DATA_WIDTH-1:0] i_M0_Data,
  output logic                  o_M0_Data_Read,
  output logic                  o_M0_Rd_Valid,
  output logic                  o_M0_Last,

  input  logic [ADDR_WIDTH-1:0] i_M1_Addr,
  input  logic                  i_M1_Req_Valid,
  input  logic                  i_M1_Read_Write_n,
  input  logic [DATA_WIDTH-1:0] i_M1_Data,
  output logic                  o_M1_Data_Read,
  output logic                  o_M1_Rd_Valid,
  output logic                  o_M1_Last,

  output logic [DATA_WIDTH-1:0] o_Rd_Data,

  output logic [ADDR_WIDTH-1:0] o_SDRAM_Addr,
  output logic                  o_SDRAM_Req_Valid,
  output logic                  o_SDRAM_Read_Write_n,
  output logic [DATA_WIDTH-1:0] o_SDRAM_Data,
  input  logic                  i_SDRAM_Data_Read,
  input  logic                  i_SDRAM_Rd_Valid,
  input  logic [DATA_WIDTH-1:0] i_SDRAM_Rd_Data,
  input  logic                  i_SDRAM_Last
);

  arb_state_t state;
  logic       last_gnt;
  logic       boot_done_seen;
  logic       req0;
  logic       req1;

  boot_reset_hold #(
    .BOOT_HOLD_CYCLES(BOOT_HOLD_CYCLES)
  ) u_boot_reset_hold (
    .i_Clk           (i_Clk),
    .i_Reset         (i_Reset),
    .i_Boot_Done     (i_Boot_Done),
    .o_Boot_Done_Seen(boot_done_seen),
    .o_CPU_Reset     (o_CPU_Reset)
  );

  assign req0 = i_M0_Req_Valid;
  assign req1 = i_M1_Req_Valid & boot_done_seen;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: state <= rr_pick(req0, req1, last_gnt);
        GNT0: begin
          if (i_SDRAM_Last) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
          end else if (!i_M0_Req_Valid) begin
            state <= IDLE;
          end
        end
        GNT1: begin
          if (i_SDRAM_Last) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
          end else if (!i_M1_Req_Valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational from state so the controller return path adds no latency.
  always_comb begin
    o_SDRAM_Addr         = '0;
    o_SDRAM_Req_Valid    = 1'b0;
    o_SDRAM_Read_Write_n = 1'b0;
    o_SDRAM_Data         = '0;
    o_M0_Data_Read       = 1'b0;
    o_M0_Rd_Valid        = 1'b0;
    o_M0_Last            = 1'b0;
    o_M1_Data_Read       = 1'b0;
    o_M1_Rd_Valid        = 1'b0;
    o_M1_Last            = 1'b0;
    case (state)
      GNT0: begin
        o_SDRAM_Addr         = i_M0_Addr;
        o_SDRAM_Req_Valid    = i_M0_Req_Valid;
        o_SDRAM_Read_Write_n = i_M0_Read_Write_n;
        o_SDRAM_Data         = i_M0_Data;
        o_M0_Data_Read       = i_SDRAM_Data_Read;
        o_M0_Rd_Valid        = i_SDRAM_Rd_Valid;
        o_M0_Last            = i_SDRAM_Last;
      end
      GNT1: begin
        o_SDRAM_Addr         = i_M1_Addr;
        o_SDRAM_Req_Valid    = i_M1_Req_Valid;
        o_SDRAM_Read_Write_n = i_M1_Read_Write_n;
        o_SDRAM_Data         = i_M1_Data;
        o_M1_Data_Read       = i_SDRAM_Data_Read;
        o_M1_Rd_Valid        = i_SDRAM_Rd_Valid;
        o_M1_Last            = i_SDRAM_Last;
      end
      default: ;
    endcase
  end

  assign o_Rd_Data = i_SDRAM_Rd_Data;

endmodule

// File: tb/tb_sdram_boot_arbiter.sv
// Self-checking bench for sdram_boot_arbiter: cycle-level owner/boot model
// plus directed burst scenarios with literal expectations.
module tb_sdram_boot_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int H  = 16;

  logic          i_Clk, i_Reset, i_Boot_Done, o_CPU_Reset;
  logic [AW-1:0] i_M0_Addr, i_M1_Addr, o_SDRAM_Addr;
  logic          i_M0_Req_Valid, i_M0_Read_Write_n, o_M0_Data_Read, o_M0_Rd_Valid, o_M0_Last;
  logic          i_M1_Req_Valid, i_M1_Read_Write_n, o_M1_Data_Read, o_M1_Rd_Valid, o_M1_Last;
  logic [DW-1:0] i_M0_Data, i_M1_Data, o_Rd_Data, o_SDRAM_Data, i_SDRAM_Rd_Data;
  logic          o_SDRAM_Req_Valid, o_SDRAM_Read_Write_n;
  logic          i_SDRAM_Data_Read, i_SDRAM_Rd_Valid, i_SDRAM_Last;

  sdram_boot_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BOOT_HOLD_CYCLES(H)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Boot_Done(i_Boot_Done), .o_CPU_Reset(o_CPU_Reset),
    .i_M0_Addr(i_M0_Addr), .i_M0_Req_Valid(i_M0_Req_Valid), .i_M0_Read_Write_n(i_M0_Read_Write_n),
    .i_M0_Data(i_M0_Data), .o_M0_Data_Read(o_M0_Data_Read), .o_M0_Rd_Valid(o_M0_Rd_Valid),
    .o_M0_Last(o_M0_Last),
    .i_M1_Addr(i_M1_Addr), .i_M1_Req_Valid(i_M1_Req_Valid), .i_M1_Read_Write_n(i_M1_Read_Write_n),
    .i_M1_Data(i_M1_Data), .o_M1_Data_Read(o_M1_Data_Read), .o_M1_Rd_Valid(o_M1_Rd_Valid),
    .o_M1_Last(o_M1_Last),
    .o_Rd_Data(o_Rd_Data),
    .o_SDRAM_Addr(o_SDRAM_Addr), .o_SDRAM_Req_Valid(o_SDRAM_Req_Valid),
    .o_SDRAM_Read_Write_n(o_SDRAM_Read_Write_n), .o_SDRAM_Data(o_SDRAM_Data),
    .i_SDRAM_Data_Read(i_SDRAM_Data_Read), .i_SDRAM_Rd_Valid(i_SDRAM_Rd_Valid),
    .i_SDRAM_Rd_Data(i_SDRAM_Rd_Data), .i_SDRAM_Last(i_SDRAM_Last)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) if (!i_Reset) cyc++;

  // Model: who owns the controller (-1 none), who finished last, and
  // how many edges have passed since boot-done was first sampled.
  int m_owner, m_last, m_since;
  bit m_seen, e0, e1;

  always @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      m_owner = -1; m_last = 1; m_seen = 0; m_since = 0;
    end else begin
      if (m_owner < 0) begin
        e0 = i_M0_Req_Valid;
        e1 = i_M1_Req_Valid && m_seen;
        if (e0 && e1)  m_owner = (m_last == 0) ? 1 : 0;
        else if (e0)   m_owner = 0;
        else if (e1)   m_owner = 1;
      end else if (i_SDRAM_Last) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!((m_owner == 0) ? i_M0_Req_Valid : i_M1_Req_Valid)) begin
        m_owner = -1;
      end
      if (m_seen) m_since++;
      else if (i_Boot_Done) begin m_seen = 1; m_since = 0; end
    end
  end

  logic [94:0]   exp_v, act_v;
  logic          x_req, x_rw, x0dr, x0rv, x0l, x1dr, x1rv, x1l, x_cpu;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_data;

  always @(negedge i_Clk) begin
    {x_req, x_rw, x0dr, x0rv, x0l, x1dr, x1rv, x1l} = '0;
    x_addr = '0;
    x_data = '0;
    if (m_owner == 0) begin
      x_req = i_M0_Req_Valid; x_rw = i_M0_Read_Write_n; x_addr = i_M0_Addr; x_data = i_M0_Data;
      x0dr = i_SDRAM_Data_Read; x0rv = i_SDRAM_Rd_Valid; x0l = i_SDRAM_Last;
    end else if (m_owner == 1) begin
      x_req = i_M1_Req_Valid; x_rw = i_M1_Read_Write_n; x_addr = i_M1_Addr; x_data = i_M1_Data;
      x1dr = i_SDRAM_Data_Read; x1rv = i_SDRAM_Rd_Valid; x1l = i_SDRAM_Last;
    end
    x_cpu = !(m_seen && (m_since > H));
    exp_v = {x_req, x_rw, x_addr, x_data, x0dr, x0rv, x0l, x1dr, x1rv, x1l, i_SDRAM_Rd_Data, x_cpu};
    act_v = {o_SDRAM_Req_Valid, o_SDRAM_Read_Write_n, o_SDRAM_Addr, o_SDRAM_Data,
             o_M0_Data_Read, o_M0_Rd_Valid, o_M0_Last, o_M1_Data_Read, o_M1_Rd_Valid,
             o_M1_Last, o_Rd_Data, o_CPU_Reset};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (!o_SDRAM_Req_Valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("grant_seen", o_SDRAM_Req_Valid, 1);
  endtask

  logic [DW-1:0] wr_pat [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [DW-1:0] rd_pat [4] = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004};
  int w, saw, p0, p1, order[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    i_Reset = 1'b1; i_Boot_Done = 1'b0;
    i_M0_Addr = '0; i_M0_Req_Valid = 0; i_M0_Read_Write_n = 0; i_M0_Data = '0;
    i_M1_Addr = '0; i_M1_Req_Valid = 0; i_M1_Read_Write_n = 0; i_M1_Data = '0;
    i_SDRAM_Data_Read = 0; i_SDRAM_Rd_Valid = 0; i_SDRAM_Rd_Data = '0; i_SDRAM_Last = 0;
    repeat (3) tick();
    chk("reset_cpu_reset", o_CPU_Reset, 1);
    chk("reset_req_valid", o_SDRAM_Req_Valid, 0);
    i_Reset = 1'b0;

    // CPU masked before boot done
    i_M1_Addr = 22'h3FFFFC; i_M1_Read_Write_n = 1; i_M1_Req_Valid = 1;
    saw = 0;
    repeat (100) begin
      tick();
      if (o_SDRAM_Req_Valid) saw++;
    end
    chk("m1_masked_no_grant", saw, 0);
    chk("m1_masked_cpu_reset", o_CPU_Reset, 1);
    i_M1_Req_Valid = 0;
    tick();

    // M0 4-beat write
    i_M0_Addr = 22'h000010; i_M0_Read_Write_n = 0; i_M0_Data = wr_pat[0]; i_M0_Req_Valid = 1;
    wait_grant(w);
    chk("m0_grant_latency", w, 1);
    chk("m0_wr_addr", o_SDRAM_Addr, 22'h000010);
    chk("m0_wr_dir", o_SDRAM_Read_Write_n, 0);
    p0 = 0; p1 = 0;
    for (int b = 0; b < 4; b++) begin
      i_M0_Data = wr_pat[b]; i_SDRAM_Data_Read = 1; i_SDRAM_Last = (b == 3);
      #1;
      chk("m0_wr_data", o_SDRAM_Data, wr_pat[b]);
      if (o_M0_Data_Read) p0++;
      if (o_M1_Data_Read) p1++;
      tick();
    end
    i_SDRAM_Data_Read = 0; i_SDRAM_Last = 0; i_M0_Req_Valid = 0;
    chk("m0_data_read_pulses", p0, 4);
    chk("m1_data_read_pulses", p1, 0);

    // Boot done at edge 200, CPU reset falls after edge 217
    while (cyc < 199) tick();
    i_Boot_Done = 1;
    tick();
    i_Boot_Done = 0;
    while (cyc < 216) tick();
    chk("cpu_reset_edge216", o_CPU_Reset, 1);
    tick();
    chk("cpu_reset_edge217", o_CPU_Reset, 0);

    // M1 4-beat read at top of memory
    i_M1_Addr = 22'h3FFFFC; i_M1_Read_Write_n = 1; i_M1_Req_Valid = 1;
    wait_grant(w);
    chk("m1_rd_addr", o_SDRAM_Addr, 22'h3FFFFC);
    chk("m1_rd_dir", o_SDRAM_Read_Write_n, 1);
    p0 = 0; p1 = 0;
    for (int b = 0; b < 4; b++) begin
      i_SDRAM_Rd_Valid = 1; i_SDRAM_Rd_Data = rd_pat[b]; i_SDRAM_Last = (b == 3);
      #1;
      chk("rd_data", o_Rd_Data, rd_pat[b]);
      if (o_M1_Rd_Valid) p1++;
      if (o_M0_Rd_Valid) p0++;
      if (b == 3) chk("m1_last_beat4", o_M1_Last, 1);
      tick();
    end
    i_SDRAM_Rd_Valid = 0; i_SDRAM_Last = 0; i_M1_Req_Valid = 0;
    chk("m1_rd_valid_pulses", p1, 4);
    chk("m0_rd_valid_pulses", p0, 0);
    tick();

    // Both masters requesting continuously: alternate with one idle cycle
    i_M0_Addr = 22'h000100; i_M1_Addr = 22'h000200;
    i_M0_Read_Write_n = 0; i_M1_Read_Write_n = 0;
    i_M0_Req_Valid = 1; i_M1_Req_Valid = 1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(w);
      chk("turnaround_gap", w, 1);
      order[k] = (o_SDRAM_Addr == 22'h000200) ? 1 : 0;
      for (int b = 0; b < 2; b++) begin
        i_SDRAM_Data_Read = 1; i_SDRAM_Last = (b == 1);
        tick();
      end
      i_SDRAM_Data_Read = 0; i_SDRAM_Last = 0;
    end
    chk("rr_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
    i_M0_Req_Valid = 0; i_M1_Req_Valid = 0;
    tick();

    // Reset during beat 2 of an M0 write
    i_M0_Addr = 22'h000040; i_M0_Data = wr_pat[0]; i_M0_Req_Valid = 1;
    wait_grant(w);
    i_SDRAM_Data_Read = 1;
    tick();
    i_M0_Data = wr_pat[1];
    #1;
    chk("beat2_data_read", o_M0_Data_Read, 1);
    i_Reset = 1;
    #1;
    chk("abort_req_valid", o_SDRAM_Req_Valid, 0);
    chk("abort_m0_data_read", o_M0_Data_Read, 0);
    chk("abort_addr", o_SDRAM_Addr, 0);
    chk("abort_cpu_reset", o_CPU_Reset, 1);
    i_SDRAM_Data_Read = 0; i_M0_Req_Valid = 0;
    tick();
    tick();
    i_Reset = 0;
    i_Boot_Done = 1;
    tick();
    i_M0_Req_Valid = 1; i_M1_Req_Valid = 1;
    wait_grant(w);
    chk("tie_after_reset_m0", o_SDRAM_Addr, 22'h000040);
    i_M0_Req_Valid = 0; i_M1_Req_Valid = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_boot_arbiter.md
# sdram_boot_arbiter

Two-master arbiter in front of the single-port SDRAM controller. Master 0 is the flash boot loader and master 1 is the CPU cache refill/writeback port. The block locks the grant for a full burst and masks the CPU port until the loader reports done. It also generates the CPU reset, which is held until the boot copy completes plus a programmable settle time.

## Interface
Parameters:
- ADDR_WIDTH, 22, SDRAM word-address bits
- DATA_WIDTH, 32, data bits per burst beat
- BOOT_HOLD_CYCLES, 16, cycles `o_CPU_Reset` stays high after `i_Boot_Done` is first seen (1..255)

Ports:
- i_Clk  in  1  memory clock; single clock domain
- i_Reset  in  1  asynchronous, active-high reset
- i_Boot_Done  in  1  loader done flag; sticky once high
- o_CPU_Reset  out  1  CPU reset request, active-high
- i_M0_Addr / i_M1_Addr  in  ADDR_WIDTH  request address
- i_M0_Req_Valid / i_M1_Req_Valid  in  1  request pending
- i_M0_Read_Write_n / i_M1_Read_Write_n  in  1  1 = read, 0 = write
- i_M0_Data / i_M1_Data  in  DATA_WIDTH  current write beat
- o_M0_Data_Read / o_M1_Data_Read  out  1  write beat consumed
- o_M0_Rd_Valid / o_M1_Rd_Valid  out  1  read beat valid
- o_M0_Last / o_M1_Last  out  1  final beat of the burst
- o_Rd_Data  out  DATA_WIDTH  read data, shared by both masters
- o_SDRAM_Addr  out  ADDR_WIDTH  address to the controller
- o_SDRAM_Req_Valid  out  1  request valid to the controller
- o_SDRAM_Read_Write_n  out  1  direction to the controller
- o_SDRAM_Data  out  DATA_WIDTH  write beat to the controller
- i_SDRAM_Data_Read  in  1  write beat consumed
- i_SDRAM_Rd_Valid  in  1  read beat valid
- i_SDRAM_Rd_Data  in  DATA_WIDTH  read data
- i_SDRAM_Last  in  1  final beat

## Operation
- The FSM has three states: IDLE, GNT0, GNT1.
- The state and the round-robin pointer `last_gnt` are registered. The datapath mux is combinational from the state.
- Eligible requests in IDLE:
  - req0 = `i_M0_Req_Valid`
  - req1 = `i_M1_Req_Valid` & boot_done_seen
- IDLE transitions:
  - Only one eligible request: grant that master.
  - Both eligible: grant the master that is not `last_gnt`.
  - The `last_gnt` reset value is 1, so M0 wins the first tie.
- GNTx behaviour:
  - The controller port mirrors master x: Addr, Req_Valid, Read_Write_n and Data.
  - `i_SDRAM_Data_Read`, `i_SDRAM_Rd_Valid` and `i_SDRAM_Last` route only to master x. The other master sees 0 on all three.
  - `o_Rd_Data` = `i_SDRAM_Rd_Data` at all times.
- Burst end:
  - `i_SDRAM_Last` high in GNTx → next state IDLE, `last_gnt` ← x.
  - The grant is never revoked mid-burst, even if the other master requests or `i_Boot_Done` changes.
- Master drops Req_Valid in GNTx without Last → return to IDLE. This is a protocol violation; the block recovers but reports no error.
- In IDLE, `o_SDRAM_Req_Valid` = 0 and the SDRAM address, data and direction outputs are 0.
- Boot sequencing:
  - boot_done_seen is set on the first high `i_Boot_Done` and cleared only by reset.
  - A hold counter loads BOOT_HOLD_CYCLES and decrements once per cycle while boot_done_seen is set.
  - `o_CPU_Reset` = 1 until the counter reaches 0.

## Timing
- Reset values: state IDLE, `last_gnt` = 1, boot_done_seen = 0, hold counter = BOOT_HOLD_CYCLES, `o_CPU_Reset` = 1. All other outputs are 0.
- Grant latency: a request sampled in IDLE at edge N gives a downstream `o_SDRAM_Req_Valid` visible after edge N, so the controller sees it one cycle after the master raised it.
- The master-to-controller return path has no added latency (combinational).
- One mandatory IDLE turnaround cycle follows every burst. This guarantees the finished master's registered Req_Valid has dropped before re-arbitration.
- Reset asserted mid-burst: everything immediately returns to reset values, and `o_SDRAM_Req_Valid` falls asynchronously. The controller must tolerate an aborted burst.
- `i_Boot_Done` rising at edge N: boot_done_seen is set at N, and `o_CPU_Reset` falls BOOT_HOLD_CYCLES+1 edges later.

## Structure
- The shared package holds the state encoding (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2) and the default ADDR_WIDTH and DATA_WIDTH.
- One natural sub-module, `boot_reset_hold`: the boot_done_seen flag, the hold counter and `o_CPU_Reset`.
- Arbitration and muxing stay in the top module.

## Test plan
- Reset release, `i_M1_Req_Valid` = 1 and `i_Boot_Done` = 0 for 100 cycles → `o_SDRAM_Req_Valid` never rises, and `o_CPU_Reset` stays 1.
- M0 4-beat write to addr 0x000010 with data 0x11111111..0x44444444 → controller sees the same address, direction and data. `o_M0_Data_Read` pulses 4 times and `o_M1_Data_Read` stays 0.
- `i_Boot_Done` pulses at cycle 200 with BOOT_HOLD_CYCLES = 16 → `o_CPU_Reset` falls after edge 217, and M1 requests are honoured afterwards.
- Both masters request continuously after boot → grants alternate M0, M1, M0, … with one IDLE cycle between bursts.
- M1 4-beat read of addr 0x3FFFFC → `o_M1_Rd_Valid` pulses 4 times, `o_M1_Last` is high on the 4th beat, and `o_M0_Rd_Valid` stays 0.
- Reset asserted during beat 2 of an M0 write → all outputs return to reset values in the same cycle. After release, the first tie is won by M0.
